// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// One access in flight at a time; illegal accesses are answered locally with a fault.
module mem_arbiter #(
  parameter logic [31:0] INST_BASE    = 32'h0040_0000,
  parameter int unsigned INST_SPACE   = 1024,
  parameter logic [31:0] STATIC_BASE  = 32'h1000_0000,
  parameter int unsigned STATIC_SPACE = 1024,
  parameter logic [31:0] DYN_BASE     = 32'h1000_8000,
  parameter int unsigned DYN_SPACE    = 1024,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] lat_cnt;
  logic       owner_i;
  logic       owner_we;

  logic idle, grant_i, grant_d, grant, g_fault, in_inst, in_any;
  req_t g;

  // 33-bit compare so a region ending exactly at 2^32 does not wrap to zero.
  function automatic logic hit(input logic [31:0] a, input logic [31:0] base,
                               input int unsigned space);
    logic [32:0] x, lo, hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + 33'(space);
    return (x >= lo) && (x < hi);
  endfunction

  always_comb begin
    // Gating with rst_n keeps the readies and strobe low while reset is held.
    idle    = (state == IDLE) && rst_n;
    grant_i = idle && if_valid && (!d_valid || (starve_cnt == STARVE_MAX));
    grant_d = idle && d_valid && !grant_i;
    grant   = grant_i || grant_d;
    g       = '0;
    if (grant_i)      g.addr = if_addr;
    else if (grant_d) g = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
    in_inst = hit(g.addr, INST_BASE, INST_SPACE);
    in_any  = in_inst || hit(g.addr, STATIC_BASE, STATIC_SPACE)
                      || hit(g.addr, DYN_BASE, DYN_SPACE);
    g_fault = (g.addr[1:0] != 2'b00) || !in_any || (grant_i && !in_inst)
           || (g.we && in_inst) || (g.we && (g.be == 4'h0));
  end

  assign if_ready  = grant_i;
  assign d_ready   = grant_d;
  assign mem_req   = grant && !g_fault;
  assign mem_we    = mem_req && g.we;
  assign mem_addr  = mem_req ? g.addr  : '0;
  assign mem_wdata = mem_req ? g.wdata : '0;
  assign mem_be    = mem_req ? g.be    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      owner_i    <= 1'b0;
      owner_we   <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_fault   <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_fault    <= 1'b0;
    end else begin
      if (!if_valid || grant_i)
        starve_cnt <= '0;
      else if (grant_d && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;

      // Response fields are single-cycle pulses; everything drops back to 0 after RESP.
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_fault  <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_fault   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant) begin
            owner_i  <= grant_i;
            owner_we <= g.we;
            if (g_fault) begin
              state     <= RESP;
              if_rvalid <= grant_i;
              if_fault  <= grant_i;
              d_rvalid  <= grant_d;
              d_fault   <= grant_d;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state     <= RESP;
            if_rvalid <= owner_i;
            d_rvalid  <= !owner_i;
            if (owner_i)        if_rdata <= mem_rdata;
            else if (!owner_we) d_rdata  <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: timing, arbitration order, faults and async reset.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid, if_fault;
  logic [31:0] if_rdata;
  logic        d_valid = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready, d_rvalid, d_fault;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_p1 = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_fault(if_fault),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns read data exactly LAT=2 cycles after the strobe; junk otherwise.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    mem_p1    <= (mem_req && !mem_we) ? mem_model(mem_addr) : 32'hBAD0_BAD0;
    mem_rdata <= mem_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk(tag, 32'(|{if_ready, if_rvalid, if_rdata, if_fault, d_ready, d_rvalid, d_rdata,
                   d_fault, mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 0);
  endtask

  // One isolated request; checks grant-cycle strobe, response latency and payload.
  task automatic do_req(input string tag, input logic fetch, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic fault_exp,
                        input logic [31:0] rdata_exp);
    int n;
    @(negedge clk);
    if (fetch) begin
      if_valid = 1'b1; if_addr = addr;
    end else begin
      d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end
    #1;
    chk({tag, "_rdy"}, fetch ? if_ready : d_ready, 1);
    chk({tag, "_other_rdy"}, fetch ? d_ready : if_ready, 0);
    chk({tag, "_req"}, mem_req, !fault_exp);
    if (!fault_exp) begin
      chk({tag, "_maddr"}, mem_addr, addr);
      chk({tag, "_mwe"}, mem_we, we);
      if (we) begin
        chk({tag, "_mwdata"}, mem_wdata, wdata);
        chk({tag, "_mbe"}, mem_be, be);
      end
    end else begin
      chk({tag, "_mzero"}, 32'(|{mem_we, mem_addr, mem_wdata, mem_be}), 0);
    end
    @(negedge clk);
    if_valid = 1'b0; d_valid = 1'b0;
    n = 1;
    while (!(fetch ? if_rvalid : d_rvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, fault_exp ? 1 : LAT + 1);
    chk({tag, "_rdata"}, fetch ? if_rdata : d_rdata, rdata_exp);
    chk({tag, "_fault"}, fetch ? if_fault : d_fault, fault_exp);
    @(negedge clk);
    chk({tag, "_rv_drop"}, fetch ? if_rvalid : d_rvalid, 0);
  endtask

  initial begin
    int n;
    logic exp_i;

    // Reset state, including with both requests asserted.
    repeat (2) @(negedge clk);
    all_zero("rst_idle");
    if_valid = 1'b1; d_valid = 1'b1; if_addr = 32'h0040_0000; d_addr = 32'h1000_0000;
    #1;
    all_zero("rst_valids");
    @(negedge clk);
    if_valid = 1'b0; d_valid = 1'b0;
    rst_n = 1'b1;

    // Basic fetch, load and store timing.
    do_req("fetch0", 1, 0, 32'h0040_0000, 0, 0, 0, 32'h0000_0013);
    do_req("st_dyn", 0, 1, 32'h1000_8000, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_req("ld_dyn_last", 0, 0, 32'h1000_83FC, 0, 4'hF, 0, 32'h4A5A_83FC);
    do_req("ld_inst", 0, 0, 32'h0040_0004, 0, 4'hF, 0, 32'h5A1A_0004);

    // Fault cases.
    do_req("f_misalign", 0, 0, 32'h1000_0002, 0, 4'hF, 1, 0);
    do_req("f_past_static", 0, 0, 32'h1000_0400, 0, 4'hF, 1, 0);
    do_req("f_st_inst", 0, 1, 32'h0040_0000, 32'h1234_5678, 4'hF, 1, 0);
    do_req("f_fetch_data", 1, 0, 32'h1000_0000, 0, 0, 1, 0);
    do_req("f_st_be0", 0, 1, 32'h1000_0000, 32'h1, 4'h0, 1, 0);
    do_req("f_fetch_mis", 1, 0, 32'h0040_0002, 0, 0, 1, 0);
    do_req("f_noregion", 0, 0, 32'hFFFF_FFFC, 0, 4'hF, 1, 0);

    // Both requesters held high: data wins four times, then fetch gets one slot.
    @(negedge clk);
    if_valid = 1'b1; if_addr = 32'h0040_0000;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0010; d_be = 4'hF;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      #1;
      while (!(if_ready || d_ready) && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      exp_i = (g == 4) || (g == 9);
      chk($sformatf("order%0d_grant", g), 32'(if_ready || d_ready), 1);
      chk($sformatf("order%0d_fetch", g), 32'(if_ready), 32'(exp_i));
      @(negedge clk);
    end
    if_valid = 1'b0; d_valid = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    // Async reset in the middle of WAIT.
    if_valid = 1'b1; if_addr = 32'h0040_0000;
    #1;
    chk("rw_grant", 32'(if_ready), 1);
    @(negedge clk);
    if_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    all_zero("rw_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if_valid = 1'b1; d_valid = 1'b1;
      #1;
      all_zero($sformatf("rw_hold%0d", c));
    end
    @(negedge clk);
    if_valid = 1'b0; d_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rw_no_rv%0d", c), 32'(if_rvalid || d_rvalid), 0);
    end
    do_req("fetch_post_rst", 1, 0, 32'h0040_0000, 0, 0, 0, 32'h0000_0013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INST_BASE, 32'h0040_0000, instruction region base.
- INST_SPACE, 1024, instruction region size in bytes.
- STATIC_BASE, 32'h1000_0000, static data region base.
- STATIC_SPACE, 1024, static region size in bytes.
- DYN_BASE, 32'h1000_8000, dynamic data (gp/sp) region base.
- DYN_SPACE, 1024, dynamic region size in bytes.
- MEM_LATENCY, 2, memory read latency in cycles, legal range 1..15.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits, legal range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- if_valid, in, 1, fetch request.
- if_addr, in, 32, fetch address.
- if_ready, out, 1, fetch request accepted this cycle.
- if_rvalid, out, 1, fetch response pulse.
- if_rdata, out, 32, fetch data.
- if_fault, out, 1, fetch fault, qualified by if_rvalid.
- d_valid, in, 1, data request.
- d_we, in, 1, store when 1.
- d_addr, in, 32, data address.
- d_wdata, in, 32, store data.
- d_be, in, 4, byte enables.
- d_ready, out, 1, data request accepted.
- d_rvalid, out, 1, data response pulse.
- d_rdata, out, 32, load data.
- d_fault, out, 1, data fault, qualified by d_rvalid.
- mem_req, out, 1, one-cycle memory access strobe.
- mem_we, out, 1, memory write.
- mem_addr, out, 32, word-aligned byte address.
- mem_wdata, out, 32, write data.
- mem_be, out, 4, write byte enables.
- mem_rdata, in, 32, valid exactly MEM_LATENCY cycles after mem_req.

Function
REQ-003 The block SHALL use a three-state FSM (IDLE, WAIT, RESP) and SHALL have at most one access outstanding.
REQ-004 In IDLE with any valid high, the block SHALL grant exactly one requester.
- Data wins by default.
- Fetch wins if starve_cnt == STARVE_LIMIT.
- Fetch wins if d_valid is low.
REQ-005 The granted requester's ready SHALL be high combinationally in that IDLE cycle, and the other ready SHALL be low; both readies SHALL be low outside IDLE.
REQ-006 starve_cnt SHALL be 4 bits.
- Increments on a data grant while if_valid is high.
- Clears on any fetch grant.
- Clears on any cycle with if_valid low.
- Saturates at STARVE_LIMIT.
REQ-007 Region decode SHALL be a hit when BASE <= addr < BASE+SPACE, computed in 33-bit arithmetic so regions ending at 2^32 do not wrap.
REQ-008 A grant SHALL fault if any of the following holds:
- addr[1:0] != 0.
- The address hits no region.
- Fetch outside the instruction region.
- Store into the instruction region.
- Store with d_be == 0.
REQ-009 A faulting grant SHALL NOT assert mem_req and SHALL go IDLE->RESP.
- The requester's rvalid and fault pulse in the next cycle.
- The requester's rdata is 0.
REQ-010 A legal grant SHALL assert mem_req for exactly the grant cycle with registered-free pass-through of addr/we/wdata/be, then enter WAIT with a latency counter loaded to MEM_LATENCY-1.
REQ-011 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0. mem_rdata SHALL be captured on the RESP entry edge (exactly MEM_LATENCY cycles after mem_req).
REQ-012 RESP SHALL last one cycle and pulse the granted requester's rvalid with fault=0, then return to IDLE.
- Load: rdata = captured mem_rdata.
- Store: rdata = 0.
- No new grant in RESP; minimum request spacing is MEM_LATENCY+2 cycles.
REQ-013 Requests deasserted before ready SHALL be dropped without side effect; request inputs SHALL be ignored outside IDLE.
REQ-014 mem_we, mem_addr, mem_wdata and mem_be SHALL be 0 whenever mem_req is 0.

Reset
REQ-015 rst_n low SHALL asynchronously force:
- FSM to IDLE.
- starve_cnt and the latency counter to 0.
- All outputs to 0, including rdata registers.
REQ-016 Reset mid-WAIT SHALL abandon the access with no rvalid emitted, and the first post-reset grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-017 Fetch 32'h0040_0000, MEM_LATENCY=2 -> mem_req cycle 0; mem_rdata=32'h0000_0013 at cycle 2; if_rvalid=1, if_rdata=32'h13, if_fault=0 at cycle 3.
REQ-018 if_valid and d_valid held high continuously with legal loads -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-019 Store d_addr=32'h1000_8000, d_be=4'hF, d_wdata=32'hDEAD_BEEF -> one mem_req with mem_we=1 and those values; d_rvalid=1, d_fault=0 three cycles later.
REQ-020 Fault cases -> no mem_req; fault pulse one cycle after grant:
- d_addr=32'h1000_0002 (misaligned).
- d_addr=32'h1000_0400 (one past the static region).
- Store to 32'h0040_0000.
- Fetch from 32'h1000_0000.
REQ-021 rst_n driven low asynchronously in WAIT, released 3 cycles later -> no rvalid ever; all outputs 0 during reset; a new fetch afterwards completes normally.
